alu_commit: RTL
===============

# alu_commit

Commit stage directly downstream of the integer ALU. It tracks the single operation in flight in the ALU and consumes the ALU's result, flags and valid/busy strobes. It evaluates the operation's condition code and issues the register-file write and condition-code update. It also generates the issue stall, hazard information and flush draining for the upstream operand stage.

## Interface

- `COND_W`, default 3: condition field width. Fixed encoding; other values are unsupported.
- `NREG_W`, default 5: register index width (32 registers).
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_ce`  in  1  upstream issues an op to the ALU this cycle; same strobe as the ALU's `i_ce`.
- `i_dst`  in  NREG_W  destination register of the issued op
- `i_wr_reg`  in  1  issued op writes a register (0 for CMP/TST)
- `i_wr_flags`  in  1  issued op updates CC
- `i_cond`  in  3  issued op condition: 0 always, 1 Z, 2 LT(N), 3 C, 4 V, 5 NZ, 6 GE(!N), 7 NC
- `i_alu_valid`  in  1  ALU result valid
- `i_alu_result`  in  32  ALU result
- `i_alu_flags`  in  4  ALU flags {V,N,C,Z}
- `i_alu_busy`  in  1  ALU multi-cycle op in progress
- `i_flush`  in  1  discard the in-flight op (branch/exception)
- `i_cc_wr`  in  1  external CC load (supervisor restore)
- `i_cc_data`  in  4  CC load value {V,N,C,Z}
- `o_stall`  out  1  upstream must not issue (combinational)
- `o_pending`  out  1  a register write is in flight
- `o_pending_reg`  out  NREG_W  destination of the in-flight write
- `o_wr_en`  out  1  register-file write strobe (registered)
- `o_wr_reg`  out  NREG_W  write index
- `o_wr_data`  out  32  write data
- `o_cc`  out  4  condition-code register {V,N,C,Z}
- `o_err`  out  1  sticky protocol error

## Operation

- States: IDLE (nothing in flight), PEND (one op captured), DRAIN (flushed op still in ALU; its result is swallowed).
- Issue is accepted when `i_ce && !o_stall && !i_flush`. On acceptance, capture dst, wr_reg, wr_flags and cond into a single slot, then go to PEND.
- `o_stall` = (state==PEND && !i_alu_valid) || state==DRAIN || i_alu_busy.
- Retire happens when `i_alu_valid` arrives in PEND. The condition is evaluated against the current `o_cc`; condition 0 always passes.
  - Pass: the write is performed if wr_reg, and `o_cc <= i_alu_flags` if wr_flags.
  - Fail: no write and no CC change.
- Retire and issue in the same cycle: the slot is replaced by the new op and the state stays PEND.
- `i_flush`:
  - In PEND with `i_alu_valid` or `!i_alu_busy`: the slot is dropped, with no write and no CC change, and the state goes to IDLE.
  - In PEND with `i_alu_busy && !i_alu_valid`: the state goes to DRAIN.
  - In DRAIN or IDLE: no effect.
  - `i_ce` is ignored while `i_flush` is high.
- DRAIN: the next `i_alu_valid` is discarded, with no write, no CC change and no error, and the state goes to IDLE.
- `i_alu_valid` in IDLE sets `o_err`. It stays set until reset; the result is discarded.
- `i_cc_wr` loads `o_cc` and has priority over a simultaneous retire flag update. The retire's register write still happens.
- `o_pending` = state==PEND && slot.wr_reg. `o_pending_reg` = slot.dst.

## Timing

- Reset values: state IDLE, `o_wr_en`=0, `o_wr_reg`=0, `o_wr_data`=0, `o_cc`=0, `o_err`=0, `o_pending`=0, `o_stall`=0 (when `i_alu_busy`=0).
- The write for a retire in cycle N appears with `o_wr_en`=1 in cycle N+1, for one cycle. `o_cc` changes at the same edge.
- The condition evaluated in cycle N sees `o_cc` including every retire up to cycle N-1.
- Back-to-back single-cycle ops: issue every cycle with zero stall.
- A 3-cycle multiply stalls upstream until its valid cycle.
- Reset mid-operation: the slot is discarded, the state goes to IDLE, and no write is issued.

## Test plan

- ADD dst=3, cond=0, wr_flags; ALU returns 0x0000_0005, flags 0 one cycle later -> `o_wr_en`=1, reg 3, data 5 the next cycle; `o_cc`=0.
- CMP sets Z (flags 4'b0001); next op cond=5 (NZ), dst=4 -> no write to r4; `o_cc` stays 4'b0001. Same op with cond=1 -> r4 written.
- Multiply with busy high 2 cycles, valid on the 3rd -> `o_stall`=1 throughout; `i_ce` pulses are ignored; `o_pending_reg` = dst; single write after valid.
- Flush while multiply busy -> DRAIN; the later valid produces no write, `o_err`=0; an issue the cycle after drain is accepted.
- `i_cc_wr`=1 with data 4'b1010, same cycle as a flag-updating retire of 4'b0001 -> `o_cc`=4'b1010; register write still occurs.
- `i_alu_valid` in IDLE -> `o_err`=1 and stays high until `i_rst`; reset asserted mid-PEND -> no `o_wr_en`.

Source files
------------

// File: rtl/alu_commit.sv
// Commit stage behind the integer ALU: tracks the one op in flight and
// retires it into the register file and condition codes. It also drives
// issue stall, hazard and flush-drain information for the operand stage.
//
// Handshake: upstream issue is accepted on a cycle where i_ce && !o_stall && !i_flush;
// the ALU delivers exactly one i_alu_valid pulse per accepted op; o_wr_en is
// a one-cycle strobe that has no back-pressure.
module alu_commit #(
    parameter int COND_W = 3,
    parameter int NREG_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ce,
    input  logic [NREG_W-1:0] i_dst,
    input  logic              i_wr_reg,
    input  logic              i_wr_flags,
    input  logic [COND_W-1:0] i_cond,
    input  logic              i_alu_valid,
    input  logic [31:0]       i_alu_result,
    input  logic [3:0]        i_alu_flags,
    input  logic              i_alu_busy,
    input  logic              i_flush,
    input  logic              i_cc_wr,
    input  logic [3:0]        i_cc_data,
    output logic              o_stall,
    output logic              o_pending,
    output logic [NREG_W-1:0] o_pending_reg,
    output logic              o_wr_en,
    output logic [NREG_W-1:0] o_wr_reg,
    output logic [31:0]       o_wr_data,
    output logic [3:0]        o_cc,
    output logic              o_err,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NREG_W-1:0] slot_dst;
    logic              slot_wr_reg;
    logic              slot_wr_flags;
    logic [COND_W-1:0] slot_cond;

    logic issue;
    logic retire;
    logic cond_pass;
    logic commit;
    logic idle_valid;

    // o_cc is {V,N,C,Z}
    always_comb begin
        cond_pass = 1'b0;
        case (slot_cond)
            3'd0:    cond_pass = 1'b1;
            3'd1:    cond_pass = o_cc[0];
            3'd2:    cond_pass = o_cc[2];
            3'd3:    cond_pass = o_cc[1];
            3'd4:    cond_pass = o_cc[3];
            3'd5:    cond_pass = !o_cc[0];
            3'd6:    cond_pass = !o_cc[2];
            3'd7:    cond_pass = !o_cc[1];
            default: cond_pass = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (issue) state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (i_flush) begin
                    // A busy ALU still owes us a result that must be swallowed.
                    if (i_alu_valid || !i_alu_busy) state_nxt = ST_IDLE;
                    else                            state_nxt = ST_DRAIN;
                end else if (i_alu_valid) begin
                    state_nxt = issue ? ST_PEND : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (i_alu_valid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        o_stall       = ((state == ST_PEND) && !i_alu_valid) || (state == ST_DRAIN) || i_alu_busy;
        issue         = i_ce && !o_stall && !i_flush;
        retire        = (state == ST_PEND) && i_alu_valid;
        commit        = retire && !i_flush && cond_pass;
        idle_valid    = (state == ST_IDLE) && i_alu_valid;
        o_pending     = (state == ST_PEND) && slot_wr_reg;
        o_pending_reg = slot_dst;
        o_dbg_state   = state;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slot_dst      <= '0;
            slot_wr_reg   <= 1'b0;
            slot_wr_flags <= 1'b0;
            slot_cond     <= '0;
        end else if (issue) begin
            slot_dst      <= i_dst;
            slot_wr_reg   <= i_wr_reg;
            slot_wr_flags <= i_wr_flags;
            slot_cond     <= i_cond;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wr_en   <= 1'b0;
            o_wr_reg  <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en <= commit && slot_wr_reg;
            if (commit && slot_wr_reg) begin
                o_wr_reg  <= slot_dst;
                o_wr_data <= i_alu_result;
            end
        end
    end

    // External CC load wins over the retiring op's flag update.
    always_ff @(posedge i_clk) begin
        if (i_rst)                           o_cc <= 4'd0;
        else if (i_cc_wr)                    o_cc <= i_cc_data;
        else if (commit && slot_wr_flags)    o_cc <= i_alu_flags;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)           o_err <= 1'b0;
        else if (idle_valid) o_err <= 1'b1;
    end

endmodule
